// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage and EX/MEM pipeline register.
// Performs the ALU operation on the ID/EX operands, picks the write-back
// register, and registers the result with its MEM/WB control bits.
// Also raises a combinational load-use stall request to decode.
// Optional build macro: EX_FORWARD_EN adds EX-to-EX forwarding from EX/MEM.
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          idex_valid,
  input  logic [31:0]   idex_instr,
  input  logic [DW-1:0] idex_op1,
  input  logic [DW-1:0] idex_op2,
  input  logic [DW-1:0] idex_ext,
  input  logic          idex_alusrc,
  input  logic          idex_regdst,
  input  logic          idex_memread,
  input  logic          idex_memwrite,
  input  logic          idex_memtoreg,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          hazard_stall,
  output logic          exmem_valid,
  output logic [DW-1:0] exmem_alu,
  output logic [DW-1:0] exmem_wdata,
  output logic [AW-1:0] exmem_dest,
  output logic          exmem_memread,
  output logic          exmem_memwrite,
  output logic          exmem_memtoreg,
  output logic          exmem_regwrite,
  output logic          exmem_ovf
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Two's-complement add overflow: operands agree in sign, result does not.
  // Subtraction passes the inverted B operand, which has the sign of -B.
  function automatic logic add_ovf(input logic signed [DW-1:0] a,
                                   input logic signed [DW-1:0] b,
                                   input logic signed [DW-1:0] r);
    return (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
  endfunction

  logic [5:0]           opc_p0;
  logic [5:0]           fn_p0;
  logic [AW-1:0]        rs_p0;
  logic [AW-1:0]        rt_p0;
  logic [AW-1:0]        rd_p0;
  logic [AW-1:0]        dest_p0;
  logic signed [DW-1:0] a_p0;
  logic signed [DW-1:0] op2_p0;
  logic signed [DW-1:0] b_p0;
  logic signed [DW-1:0] res_p0;
  logic                 vld_p0;
  logic                 ovf_p0;
  logic                 known_p0;
  logic                 mem_ok_p0;
  logic                 rw_p0;
  logic                 mr_p0;
  logic                 mw_p0;
  logic                 m2r_p0;
  logic                 unused_shamt_p0;
`ifdef EX_FORWARD_EN
  logic                 fwd_ok_p0;
`endif

  assign opc_p0          = idex_instr[31:26];
  assign rs_p0           = AW'(idex_instr[25:21]);
  assign rt_p0           = AW'(idex_instr[20:16]);
  assign rd_p0           = AW'(idex_instr[15:11]);
  assign fn_p0           = idex_instr[5:0];
  assign unused_shamt_p0 = ^idex_instr[10:6];

  assign hazard_stall = idex_valid & idex_memread & (rt_p0 != '0) &
                        ((rt_p0 == id_rs) | (rt_p0 == id_rt));

  // EX stage: operand select, ALU, destination and control qualification
  always_comb begin
    vld_p0 = idex_valid;
    a_p0   = idex_op1;
    op2_p0 = idex_op2;
`ifdef EX_FORWARD_EN
    fwd_ok_p0 = exmem_valid & exmem_regwrite & ~exmem_memread & (exmem_dest != '0);
    if (fwd_ok_p0 && (exmem_dest == rs_p0)) a_p0 = exmem_alu;
    if (fwd_ok_p0 && (exmem_dest == rt_p0)) op2_p0 = exmem_alu;
`endif
    b_p0     = idex_alusrc ? $signed(idex_ext) : op2_p0;
    dest_p0  = idex_regdst ? rt_p0 : rd_p0;
    res_p0   = '0;
    ovf_p0   = 1'b0;
    known_p0 = 1'b0;
    case (opc_p0)
      OP_RTYPE: begin
        known_p0 = 1'b1;
        case (fn_p0)
          FN_ADD: begin
            res_p0 = a_p0 + b_p0;
            ovf_p0 = add_ovf(a_p0, b_p0, res_p0);
          end
          FN_SUB: begin
            res_p0 = a_p0 - b_p0;
            ovf_p0 = add_ovf(a_p0, ~b_p0, res_p0);
          end
          FN_AND:  res_p0 = a_p0 & b_p0;
          FN_OR:   res_p0 = a_p0 | b_p0;
          FN_NOR:  res_p0 = ~(a_p0 | b_p0);
          FN_SLT:  res_p0 = {{(DW-1){1'b0}}, (a_p0 < b_p0)};
          default: known_p0 = 1'b0;
        endcase
      end
      OP_LW, OP_SW: res_p0 = a_p0 + b_p0;
      default:      res_p0 = '0;
    endcase
    mem_ok_p0 = (opc_p0 == OP_RTYPE) || (opc_p0 == OP_LW) || (opc_p0 == OP_SW);
    mr_p0     = vld_p0 & idex_memread & mem_ok_p0;
    mw_p0     = vld_p0 & idex_memwrite & mem_ok_p0;
    m2r_p0    = vld_p0 & idex_memtoreg;
    rw_p0     = vld_p0 && (dest_p0 != '0) &&
                (((opc_p0 == OP_RTYPE) && known_p0) || (opc_p0 == OP_LW));
    ovf_p0    = ovf_p0 & vld_p0;
  end

  // EX/MEM boundary: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      exmem_valid    <= 1'b0;
      exmem_alu      <= '0;
      exmem_wdata    <= '0;
      exmem_dest     <= '0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_regwrite <= 1'b0;
      exmem_ovf      <= 1'b0;
    end else if (!stall_i) begin
      exmem_valid    <= vld_p0;
      exmem_alu      <= res_p0;
      exmem_wdata    <= op2_p0;
      exmem_dest     <= dest_p0;
      exmem_memread  <= mr_p0;
      exmem_memwrite <= mw_p0;
      exmem_memtoreg <= m2r_p0;
      exmem_regwrite <= rw_p0;
      exmem_ovf      <= ovf_p0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios plus randomized traffic,
// checked against a behavioural model of the EX/MEM register contents.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        ovf;
  } exm_t;

  logic        clk = 1'b0;
  logic        reset, valid, alusrc, regdst, memread, memwrite, memtoreg, stall, flush;
  logic [31:0] instr, op1, op2, ext;
  logic [4:0]  id_rs, id_rt;
  logic        hazard_stall, exmem_valid, exmem_memread, exmem_memwrite;
  logic        exmem_memtoreg, exmem_regwrite, exmem_ovf;
  logic [31:0] exmem_alu, exmem_wdata;
  logic [4:0]  exmem_dest;
  exm_t        got;
  exm_t        exp = '0;
  exm_t        frozen;
  logic        exp_hz;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .idex_valid(valid), .idex_instr(instr),
    .idex_op1(op1), .idex_op2(op2), .idex_ext(ext), .idex_alusrc(alusrc),
    .idex_regdst(regdst), .idex_memread(memread), .idex_memwrite(memwrite),
    .idex_memtoreg(memtoreg), .id_rs(id_rs), .id_rt(id_rt), .stall_i(stall),
    .flush_i(flush), .hazard_stall(hazard_stall), .exmem_valid(exmem_valid),
    .exmem_alu(exmem_alu), .exmem_wdata(exmem_wdata), .exmem_dest(exmem_dest),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_memtoreg(exmem_memtoreg), .exmem_regwrite(exmem_regwrite),
    .exmem_ovf(exmem_ovf)
  );

  assign got = {exmem_valid, exmem_alu, exmem_wdata, exmem_dest, exmem_memread,
                exmem_memwrite, exmem_memtoreg, exmem_regwrite, exmem_ovf};

  function automatic logic [31:0] mk_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] mk_i(logic [5:0] opc, int rs, int rt, logic [15:0] imm);
    return {opc, 5'(rs), 5'(rt), imm};
  endfunction

  // What the instruction currently presented should leave in EX/MEM.
  function automatic exm_t model_next();
    exm_t        n;
    logic [31:0] a, b2, b;
    logic [5:0]  opc;
    logic [5:0]  fn;
    int          rs, rt, rd;
    longint      s;
    bit          arith, known;
    opc = instr[31:26];
    fn  = instr[5:0];
    rs  = int'(instr[25:21]);
    rt  = int'(instr[20:16]);
    rd  = int'(instr[15:11]);
    a   = op1;
    b2  = op2;
`ifdef EX_FORWARD_EN
    if (exp.valid && exp.rw && !exp.mr && exp.dest != 0) begin
      if (int'(exp.dest) == rs) a = exp.alu;
      if (int'(exp.dest) == rt) b2 = exp.alu;
    end
`endif
    b      = alusrc ? ext : b2;
    n      = '0;
    n.valid = valid;
    n.wdata = b2;
    n.dest  = regdst ? 5'(rt) : 5'(rd);
    arith  = 0;
    known  = 0;
    s      = 0;
    if (opc == 6'd0) begin
      known = 1;
      if (fn == 6'd32)      begin n.alu = a + b; s = longint'($signed(a)) + longint'($signed(b)); arith = 1; end
      else if (fn == 6'd34) begin n.alu = a - b; s = longint'($signed(a)) - longint'($signed(b)); arith = 1; end
      else if (fn == 6'd36) n.alu = a & b;
      else if (fn == 6'd37) n.alu = a | b;
      else if (fn == 6'd39) n.alu = ~(a | b);
      else if (fn == 6'd42) n.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else known = 0;
    end else if (opc == 6'h23 || opc == 6'h2B) begin
      n.alu = a + b;
    end
    n.ovf = valid && arith && (s > 64'sd2147483647 || s < -64'sd2147483648);
    n.mr  = valid && memread && (opc == 6'd0 || opc == 6'h23 || opc == 6'h2B);
    n.mw  = valid && memwrite && (opc == 6'd0 || opc == 6'h23 || opc == 6'h2B);
    n.m2r = valid && memtoreg;
    n.rw  = valid && n.dest != 0 && ((opc == 6'd0 && known) || opc == 6'h23);
    return n;
  endfunction

  // Advance one clock edge, updating the model with the same priorities.
  task automatic tick();
    exm_t nx;
    if (reset || flush) nx = '0;
    else if (stall)     nx = exp;
    else                nx = model_next();
    @(posedge clk);
    exp = nx;
    #1;
  endtask

  task automatic set_idle();
    valid = 0; instr = 0; op1 = 0; op2 = 0; ext = 0; alusrc = 0; regdst = 0;
    memread = 0; memwrite = 0; memtoreg = 0; id_rs = 0; id_rt = 0;
    stall = 0; flush = 0;
  endtask

  task automatic randomize_inputs();
    valid = 1'($urandom); instr = $urandom; op1 = $urandom; op2 = $urandom;
    ext = $urandom; alusrc = 1'($urandom); regdst = 1'($urandom);
    memread = 1'($urandom); memwrite = 1'($urandom); memtoreg = 1'($urandom);
    id_rs = 5'($urandom); id_rt = 5'($urandom);
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      stall = 1'($urandom);
      flush = 1'($urandom);
      tick();
    end
    n_vec++;
    if (got !== 75'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h required=0", got);
    end
    reset = 0;
    set_idle();
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hazard got=%b required=0", hazard_stall);
    end
  endtask

  task automatic test_add();
    set_idle();
    valid = 1; instr = mk_r(1, 2, 5, 6'd32); op1 = 5; op2 = 7;
    tick();
    n_vec++;
    if (exmem_alu !== 32'd12 || exmem_regwrite !== 1'b1 || exmem_dest !== 5'd5 || exmem_valid !== 1'b1) begin
      n_err++;
      $display("FAIL first_add got alu=%0d rw=%b dest=%0d v=%b required alu=12 rw=1 dest=5 v=1",
               exmem_alu, exmem_regwrite, exmem_dest, exmem_valid);
    end
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL first_add_model got=%h required=%h", got, exp);
    end
  endtask

  task automatic test_lw_hazard();
    set_idle();
    valid = 1; instr = mk_i(6'h23, 1, 8, 16'hFFFC); op1 = 32'h100; ext = 32'hFFFFFFFC;
    alusrc = 1; regdst = 1; memread = 1; memtoreg = 1; id_rs = 8; id_rt = 0;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL lw_hazard_hit got=%b required=1", hazard_stall);
    end
    id_rs = 9; id_rt = 9;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL lw_hazard_miss got=%b required=0", hazard_stall);
    end
    tick();
    n_vec++;
    if (exmem_alu !== 32'hFC || exmem_memread !== 1'b1 || exmem_dest !== 5'd8 || exmem_regwrite !== 1'b1) begin
      n_err++;
      $display("FAIL lw_result got alu=%h mr=%b dest=%0d rw=%b required alu=fc mr=1 dest=8 rw=1",
               exmem_alu, exmem_memread, exmem_dest, exmem_regwrite);
    end
  endtask

  task automatic test_arith();
    set_idle();
    valid = 1; instr = mk_r(1, 2, 6, 6'd34); op1 = 32'h80000000; op2 = 1;
    tick();
    n_vec++;
    if (exmem_alu !== 32'h7FFFFFFF || exmem_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL sub_ovf got alu=%h ovf=%b required alu=7fffffff ovf=1", exmem_alu, exmem_ovf);
    end
    instr = mk_r(1, 2, 7, 6'd42); op1 = 32'hFFFFFFFF; op2 = 1;
    tick();
    n_vec++;
    if (exmem_alu !== 32'd1 || exmem_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL slt_signed got alu=%h ovf=%b required alu=1 ovf=0", exmem_alu, exmem_ovf);
    end
    instr = mk_r(1, 2, 0, 6'd32); op1 = 3; op2 = 4;
    tick();
    n_vec++;
    if (exmem_regwrite !== 1'b0 || exmem_alu !== 32'd7) begin
      n_err++;
      $display("FAIL rd_zero got rw=%b alu=%0d required rw=0 alu=7", exmem_regwrite, exmem_alu);
    end
  endtask

  task automatic test_stall_flush();
    set_idle();
    valid = 1; instr = mk_i(6'h2B, 1, 2, 16'h0010); op1 = 32'h200; op2 = 32'hCAFEF00D;
    ext = 32'h10; alusrc = 1; regdst = 1; memwrite = 1;
    tick();
    frozen = got;
    n_vec++;
    if (got !== exp || exmem_alu !== 32'h210 || exmem_wdata !== 32'hCAFEF00D || exmem_regwrite !== 1'b0) begin
      n_err++;
      $display("FAIL sw_load got=%h required=%h", got, exp);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
      n_vec++;
      if (got !== frozen || exmem_memwrite !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d got=%h required=%h", i, got, frozen);
      end
    end
    flush = 1;
    tick();
    n_vec++;
    if (exmem_valid !== 1'b0 || exmem_memwrite !== 1'b0 || got !== 75'd0) begin
      n_err++;
      $display("FAIL flush_over_stall got=%h required=0", got);
    end
    flush = 0;
    set_idle();
    valid = 1; instr = mk_r(1, 2, 3, 6'd37); op1 = 1; op2 = 2;
    tick();
    stall = 1; reset = 1;
    tick();
    reset = 0;
    n_vec++;
    if (got !== 75'd0) begin
      n_err++;
      $display("FAIL reset_while_stalled got=%h required=0", got);
    end
  endtask

  task automatic test_bubble_illegal();
    set_idle();
    valid = 0; instr = mk_i(6'h23, 1, 8, 16'h4); op1 = 4; ext = 4;
    alusrc = 1; regdst = 1; memread = 1; memwrite = 1; memtoreg = 1; id_rs = 8;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL bubble_hazard got=%b required=0", hazard_stall);
    end
    tick();
    n_vec++;
    if (exmem_valid !== 1'b0 || exmem_regwrite !== 1'b0 || exmem_memread !== 1'b0 || exmem_memwrite !== 1'b0) begin
      n_err++;
      $display("FAIL bubble got v=%b rw=%b mr=%b mw=%b required all 0",
               exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite);
    end
    valid = 1; instr = mk_i(6'b000010, 1, 8, 16'h4);
    tick();
    n_vec++;
    if (exmem_valid !== 1'b1 || exmem_regwrite !== 1'b0 || exmem_memread !== 1'b0 ||
        exmem_memwrite !== 1'b0 || exmem_alu !== 32'd0) begin
      n_err++;
      $display("FAIL illegal_op got v=%b rw=%b mr=%b mw=%b alu=%h required v=1 others 0",
               exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_alu);
    end
  endtask

  task automatic test_forward();
    logic [31:0] want;
`ifdef EX_FORWARD_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    set_idle();
    valid = 1; instr = mk_r(1, 2, 3, 6'd32); op1 = 2; op2 = 3;
    tick();
    instr = mk_r(3, 3, 4, 6'd32); op1 = 0; op2 = 0;
    tick();
    n_vec++;
    if (exmem_alu !== want || got !== exp) begin
      n_err++;
      $display("FAIL forward_add got alu=%0d required alu=%0d", exmem_alu, want);
    end
  endtask

  task automatic test_random();
    logic [5:0] fns [7];
    logic [5:0] opcs [4];
    fns  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0};
    opcs = '{6'd0, 6'h23, 6'h2B, 6'd2};
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      instr[31:26] = opcs[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) instr[31:26] = 6'($urandom);
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      instr[15:11] = 5'($urandom_range(0, 7));
      instr[5:0]   = fns[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) instr[5:0] = 6'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        op1 = 32'h80000000 ^ 32'($urandom_range(0, 3));
        op2 = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3));
      end
      valid  = ($urandom_range(0, 4) != 0);
      id_rs  = 5'($urandom_range(0, 7));
      id_rt  = 5'($urandom_range(0, 7));
      stall  = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      reset  = ($urandom_range(0, 49) == 0);
      exp_hz = valid && memread && instr[20:16] != 0 &&
               (instr[20:16] == id_rs || instr[20:16] == id_rt);
      #1;
      n_vec++;
      if (hazard_stall !== exp_hz) begin
        n_err++;
        $display("FAIL rand_hazard %0d got=%b required=%b", i, hazard_stall, exp_hz);
      end
      tick();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rand_exmem %0d got=%h required=%h", i, got, exp);
      end
    end
    reset = 0; stall = 0; flush = 0;
  endtask

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_add();
    test_lw_hazard();
    test_arith();
    test_stall_flush();
    test_bubble_illegal();
    test_forward();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register: consumer end of the ID/EX register interface.
- Takes the latched operands, instruction word and decoded control bits (ALUSrc, RegDst, MemRead, MemWrite, MemtoReg) and performs the ALU operation.
- Selects the destination register and registers the result with its control into the MEM stage.
- Also flags load-use hazards back to the decode stage.

Parameters:
- DW, 32, datapath width (operands, result, store data).
- AW, 5, register-file index width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- idex_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- idex_instr  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct
- idex_op1  in  DW  rs operand
- idex_op2  in  DW  rt operand / store data
- idex_ext  in  DW  sign-extended immediate
- idex_alusrc, idex_regdst, idex_memread, idex_memwrite, idex_memtoreg  in  1 each  ID/EX control bits
- id_rs, id_rt  in  AW each  source indices of the instruction currently in ID
- stall_i  in  1  downstream hold request
- flush_i  in  1  squash the instruction entering EX/MEM
- hazard_stall  out  1  combinational load-use stall request to ID
- exmem_valid  out  1  EX/MEM holds a real instruction
- exmem_alu  out  DW  ALU result / memory address
- exmem_wdata  out  DW  store data (B operand before ALUSrc mux)
- exmem_dest  out  AW  write-back register index
- exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite  out  1 each  MEM/WB control
- exmem_ovf  out  1  signed add/sub overflow; flag only, no trap

Behaviour:
- Reset: all outputs registered 0 (hazard_stall also 0, since it is gated by idex_valid, which must be 0 after reset).
- Register update priority each rising edge: reset > flush_i > stall_i > load.
  - Flush: exmem_valid and all control outputs cleared to 0; data outputs cleared to 0.
  - Stall: every output register holds its value.
- Latency: 1 cycle from ID/EX inputs to exmem_* outputs. A stalled cycle adds one cycle per cycle held.
- Operand B:
  - idex_alusrc = 1 selects idex_ext.
  - idex_alusrc = 0 selects idex_op2.
  - exmem_wdata is always the (forwarded) op2.
- Destination:
  - idex_regdst = 1 selects rt = instr[20:16].
  - idex_regdst = 0 selects rd = instr[15:11].
- Opcode 000000 (R-type) decodes funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed, result 1 or 0).
  - Unknown funct: result 0, regwrite 0.
- Opcodes 100011 (lw) and 101011 (sw): result = A + B (address); no overflow flag.
- All other opcodes: result 0, regwrite 0, memread/memwrite forced 0.
- exmem_regwrite = 1 only for valid R-type with known funct and dest != 0, or valid lw with dest != 0. Never for sw.
- Arithmetic: modulo 2^DW. Overflow set on add/sub when operand signs agree and result sign differs (sub uses negated B).
- idex_valid = 0 loads a bubble: valid and all control outputs 0.
- hazard_stall = idex_valid & idex_memread & (rt != 0) & (rt == id_rs | rt == id_rt). Upstream must hold ID and insert a bubble.
- Flush and stall asserted together: flush wins.
- Reset asserted while stalled: outputs cleared.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined:
  - EX-to-EX forwarding from the EX/MEM register. If exmem_valid & exmem_regwrite & !exmem_memread & exmem_dest != 0, exmem_alu replaces A when exmem_dest == instr rs, and replaces op2 when exmem_dest == instr rt.
  - Forwarding applies before the ALUSrc mux and to exmem_wdata.
  - A stalled EX/MEM register still forwards its held value.
- Undefined:
  - Operands are used exactly as presented.
  - Upstream inserts stalls for all RAW distances.

Test Plan:
- Reset held 2 cycles with random inputs -> all outputs 0. First load after release: add op1 = 5, op2 = 7 -> exmem_alu = 12, exmem_regwrite = 1, exmem_dest = rd, one cycle later.
- lw: op1 = 0x100, ext = 0xFFFFFFFC, alusrc = 1, regdst = 1, rt = 8 -> exmem_alu = 0xFC, exmem_memread = 1, exmem_dest = 8. Same cycle with id_rs = 8 -> hazard_stall = 1; with id_rs = id_rt = 9 -> 0.
- sub 0x80000000 - 1 -> exmem_alu = 0x7FFFFFFF, exmem_ovf = 1. slt -1 < 1 -> 1. R-type with rd = 0 -> exmem_regwrite = 0.
- Load sw, then stall_i for 3 cycles while the inputs change -> outputs frozen, exmem_memwrite = 1 throughout. flush_i together with stall_i -> next cycle exmem_valid = 0, exmem_memwrite = 0.
- idex_valid = 0, and opcode 000010 with valid = 1 -> exmem_valid follows idex_valid, but regwrite, memread and memwrite are 0 in both cases.
- EX_FORWARD_EN: add r3 = 2 + 3, then add r4 = r3 + r3 with stale operands 0 -> exmem_alu = 10. Without the macro -> 0.
